piece_cursor_ctrl: RTL and testbench

Sequences movement of N_OBJ on-screen objects (checkers/markers) for the VGA backgammon display.
- Converts held direction buttons into frame-synchronous position steps with auto-repeat.
- Selects which object is active; only the active object moves.
- Applies screen wrap-around.
- Owns all object position registers; the pixel renderer consumes the packed positions combinationally.

---
 rtl/piece_cursor_ctrl.sv | 238 +++++++++++++++++++++++
 tb/tb_piece_cursor_ctrl.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/piece_cursor_ctrl.sv
// Frame-synchronous cursor/object mover with auto-repeat, selection and screen wrap.
// Optional macro DIAG_MOVE_EN: one horizontal and one vertical step may occur together.
module piece_cursor_ctrl #(
  parameter int N_OBJ        = 3,
  parameter int STEP         = 2,
  parameter int H_MIN        = 144,
  parameter int H_MAX        = 783,
  parameter int V_MIN        = 35,
  parameter int V_MAX        = 515,
  parameter int REPEAT_DELAY = 4,
  parameter int REPEAT_RATE  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 frame_tick,
  input  logic                 btn_up,
  input  logic                 btn_down,
  input  logic                 btn_left,
  input  logic                 btn_right,
  input  logic                 btn_sel,
  output logic [1:0]           sel_idx,
  output logic [10*N_OBJ-1:0]  xpos_flat,
  output logic [10*N_OBJ-1:0]  ypos_flat,
  output logic                 step_pulse
);

  localparam int               CNT_W    = 8;
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam int               X_GAP    = (H_MAX - H_MIN) / (N_OBJ + 1);
  localparam logic [9:0]       Y_INIT   = 10'((V_MIN + V_MAX) / 2);

  localparam logic [1:0] H_NONE  = 2'b00;
  localparam logic [1:0] H_RIGHT = 2'b01;
  localparam logic [1:0] H_LEFT  = 2'b10;
  localparam logic [1:0] V_NONE  = 2'b00;
  localparam logic [1:0] V_UP    = 2'b01;
  localparam logic [1:0] V_DOWN  = 2'b10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       hdir_q, hdir_d;
  logic [1:0]       vdir_q, vdir_d;
  logic [1:0]       sel_q, sel_d;
  logic             sel_prev_q, sel_prev_d;
  logic             step_q, step_d;
  logic [9:0]       x_q [N_OBJ];
  logic [9:0]       x_d [N_OBJ];
  logic [9:0]       y_q [N_OBJ];
  logic [9:0]       y_d [N_OBJ];

  logic [1:0]       hdir_s, vdir_s;
  logic             dir_any_s, dir_chg_s, sel_edge_s;

  function automatic logic [9:0] x_init(input int k);
    return 10'(H_MIN + (k + 1) * X_GAP);
  endfunction

  function automatic logic [9:0] step_x(input logic [9:0] x, input logic [1:0] h);
    logic [10:0] sum;
    logic [9:0]  res;
    sum = {1'b0, x} + 11'(STEP);
    case (h)
      H_RIGHT: res = (sum > 11'(H_MAX)) ? 10'(H_MIN) : sum[9:0];
      H_LEFT:  res = ({1'b0, x} < 11'(H_MIN + STEP)) ? 10'(H_MAX) : (x - 10'(STEP));
      default: res = x;
    endcase
    return res;
  endfunction

  function automatic logic [9:0] step_y(input logic [9:0] y, input logic [1:0] v);
    logic [10:0] sum;
    logic [9:0]  res;
    sum = {1'b0, y} + 11'(STEP);
    case (v)
      V_DOWN:  res = (sum > 11'(V_MAX)) ? 10'(V_MIN) : sum[9:0];
      V_UP:    res = ({1'b0, y} < 11'(V_MIN + STEP)) ? 10'(V_MAX) : (y - 10'(STEP));
      default: res = y;
    endcase
    return res;
  endfunction

  // Button decode into a {horizontal, vertical} direction pair.
  always_comb begin
    hdir_s = H_NONE;
    vdir_s = V_NONE;
`ifdef DIAG_MOVE_EN
    if (btn_right)     hdir_s = H_RIGHT;
    else if (btn_left) hdir_s = H_LEFT;
    else               hdir_s = H_NONE;
    if (btn_up)        vdir_s = V_UP;
    else if (btn_down) vdir_s = V_DOWN;
    else               vdir_s = V_NONE;
`else
    if (btn_right)     hdir_s = H_RIGHT;
    else if (btn_left) hdir_s = H_LEFT;
    else if (btn_up)   vdir_s = V_UP;
    else if (btn_down) vdir_s = V_DOWN;
    else begin
      hdir_s = H_NONE;
      vdir_s = V_NONE;
    end
`endif
  end

  assign dir_any_s  = (hdir_s != H_NONE) || (vdir_s != V_NONE);
  assign dir_chg_s  = (hdir_s != hdir_q) || (vdir_s != vdir_q);
  assign sel_edge_s = btn_sel & ~sel_prev_q;

  // Auto-repeat sequencing; every step moves in the currently pressed direction.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hdir_d  = hdir_q;
    vdir_d  = vdir_q;
    step_d  = 1'b0;
    if (frame_tick) begin
      case (state_q)
        IDLE: begin
          if (dir_any_s) begin
            step_d  = 1'b1;
            hdir_d  = hdir_s;
            vdir_d  = vdir_s;
            cnt_d   = CNT_ZERO;
            state_d = DELAY;
          end else begin
            state_d = IDLE;
          end
        end
        DELAY: begin
          if (!dir_any_s) begin
            state_d = IDLE;
          end else if (dir_chg_s) begin
            step_d = 1'b1;
            hdir_d = hdir_s;
            vdir_d = vdir_s;
            cnt_d  = CNT_ZERO;
          end else if (cnt_q == CNT_W'(REPEAT_DELAY - 1)) begin
            step_d  = 1'b1;
            cnt_d   = CNT_ZERO;
            state_d = REPEAT;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        REPEAT: begin
          if (!dir_any_s) begin
            state_d = IDLE;
          end else if (dir_chg_s) begin
            step_d  = 1'b1;
            hdir_d  = hdir_s;
            vdir_d  = vdir_s;
            cnt_d   = CNT_ZERO;
            state_d = DELAY;
          end else if (cnt_q == CNT_W'(REPEAT_RATE - 1)) begin
            step_d = 1'b1;
            cnt_d  = CNT_ZERO;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = CNT_ZERO;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Selection only advances while idle with nothing pressed; other edges are dropped.
  always_comb begin
    sel_d      = sel_q;
    sel_prev_d = btn_sel;
    if (sel_edge_s && (state_q == IDLE) && !dir_any_s) begin
      if (sel_q == 2'(N_OBJ - 1)) sel_d = 2'd0;
      else                        sel_d = sel_q + 2'd1;
    end else begin
      sel_d = sel_q;
    end
  end

  always_comb begin
    for (int k = 0; k < N_OBJ; k++) begin
      if (step_d && (sel_q == 2'(k))) begin
        x_d[k] = step_x(x_q[k], hdir_s);
        y_d[k] = step_y(y_q[k], vdir_s);
      end else begin
        x_d[k] = x_q[k];
        y_d[k] = y_q[k];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= CNT_ZERO;
      hdir_q     <= H_NONE;
      vdir_q     <= V_NONE;
      sel_q      <= 2'd0;
      sel_prev_q <= 1'b0;
      step_q     <= 1'b0;
      for (int k = 0; k < N_OBJ; k++) begin
        x_q[k] <= x_init(k);
        y_q[k] <= Y_INIT;
      end
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      hdir_q     <= hdir_d;
      vdir_q     <= vdir_d;
      sel_q      <= sel_d;
      sel_prev_q <= sel_prev_d;
      step_q     <= step_d;
      for (int k = 0; k < N_OBJ; k++) begin
        x_q[k] <= x_d[k];
        y_q[k] <= y_d[k];
      end
    end
  end

  for (genvar g = 0; g < N_OBJ; g++) begin : g_pack
    assign xpos_flat[10*g +: 10] = x_q[g];
    assign ypos_flat[10*g +: 10] = y_q[g];
  end

  assign sel_idx    = sel_q;
  assign step_pulse = step_q;

endmodule

// File: tb/tb_piece_cursor_ctrl.sv
// Scoreboard bench for piece_cursor_ctrl: a behavioural model queues the expected state per cycle.
module tb_piece_cursor_ctrl;

  localparam int N_OBJ = 3;
  localparam int STEP  = 2;
  localparam int H_MIN = 144;
  localparam int H_MAX = 783;
  localparam int V_MIN = 35;
  localparam int V_MAX = 515;
  localparam int RDLY  = 4;
  localparam int RRATE = 2;

  // {sel, right, left, up, down}
  localparam logic [4:0] B_NONE  = 5'b00000;
  localparam logic [4:0] B_DOWN  = 5'b00001;
  localparam logic [4:0] B_UP    = 5'b00010;
  localparam logic [4:0] B_LEFT  = 5'b00100;
  localparam logic [4:0] B_RIGHT = 5'b01000;
  localparam logic [4:0] B_SEL   = 5'b10000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        frame_tick = 1'b0;
  logic        btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0, btn_sel = 1'b0;
  logic [1:0]  sel_idx;
  logic [29:0] xpos_flat, ypos_flat;
  logic        step_pulse;

  always #5 clk = ~clk;

  piece_cursor_ctrl dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
    .btn_sel(btn_sel), .sel_idx(sel_idx), .xpos_flat(xpos_flat), .ypos_flat(ypos_flat),
    .step_pulse(step_pulse)
  );

  typedef struct packed {
    logic [29:0] x;
    logic [29:0] y;
    logic [1:0]  sel;
    logic        pulse;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0, n_err = 0, n_pulse = 0;
  int   mx[N_OBJ], my[N_OBJ];
  int   msel, mstate, mcnt, mh, mv;
  bit   mprev;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_cmp++;
    if (obs !== want) begin
      n_err++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, want);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < N_OBJ; k++) begin
      mx[k] = H_MIN + (k + 1) * ((H_MAX - H_MIN) / (N_OBJ + 1));
      my[k] = (V_MIN + V_MAX) / 2;
    end
    msel = 0; mstate = 0; mcnt = 0; mh = 0; mv = 0; mprev = 1'b0;
  endtask

  // Computes the state expected after the coming clock edge from the inputs now driven.
  task automatic model_cycle(output exp_t e);
    int  h, v;
    bit  any, stp;
    h = 0; v = 0; stp = 1'b0;
`ifdef DIAG_MOVE_EN
    if (btn_right) h = 1; else if (btn_left) h = 2;
    if (btn_up) v = 1; else if (btn_down) v = 2;
`else
    if (btn_right) h = 1; else if (btn_left) h = 2; else if (btn_up) v = 1; else if (btn_down) v = 2;
`endif
    any = (h != 0) || (v != 0);
    if (rst) begin
      model_reset();
    end else begin
      if (btn_sel && !mprev && mstate == 0 && !any) msel = (msel + 1) % N_OBJ;
      if (frame_tick) begin
        if (mstate == 0) begin
          if (any) begin stp = 1'b1; mh = h; mv = v; mcnt = 0; mstate = 1; end
        end else if (!any) begin
          mstate = 0;
        end else if (h != mh || v != mv) begin
          stp = 1'b1; mh = h; mv = v; mcnt = 0; mstate = 1;
        end else if (mcnt == ((mstate == 1) ? RDLY - 1 : RRATE - 1)) begin
          stp = 1'b1; mcnt = 0; mstate = 2;
        end else begin
          mcnt++;
        end
      end
      if (stp) begin
        if (h == 1) mx[msel] = (mx[msel] + STEP > H_MAX) ? H_MIN : mx[msel] + STEP;
        if (h == 2) mx[msel] = (mx[msel] < H_MIN + STEP) ? H_MAX : mx[msel] - STEP;
        if (v == 2) my[msel] = (my[msel] + STEP > V_MAX) ? V_MIN : my[msel] + STEP;
        if (v == 1) my[msel] = (my[msel] < V_MIN + STEP) ? V_MAX : my[msel] - STEP;
      end
      mprev = btn_sel;
    end
    for (int k = 0; k < N_OBJ; k++) begin
      e.x[10*k +: 10] = 10'(mx[k]);
      e.y[10*k +: 10] = 10'(my[k]);
    end
    e.sel   = 2'(msel);
    e.pulse = stp;
  endtask

  task automatic run(input bit ft, input logic [4:0] b, input bit r);
    exp_t e;
    @(negedge clk);
    rst = r;
    frame_tick = ft;
    {btn_sel, btn_right, btn_left, btn_up, btn_down} = b;
    model_cycle(e);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check_val("xpos", 32'(xpos_flat), 32'(e.x));
    check_val("ypos", 32'(ypos_flat), 32'(e.y));
    check_val("sel_idx", 32'(sel_idx), 32'(e.sel));
    check_val("step_pulse", 32'(step_pulse), 32'(e.pulse));
    if (step_pulse === 1'b1) n_pulse++;
  endtask

  task automatic frames(input int n, input logic [4:0] b);
    for (int i = 0; i < n; i++) begin
      run(1'b1, b, 1'b0);
      run(1'b0, b, 1'b0);
      run(1'b0, b, 1'b0);
    end
  endtask

  task automatic tap(input logic [4:0] b);
    frames(1, b);
    frames(1, B_NONE);
  endtask

  task automatic check_reset_state(input string tag);
    check_val({tag, "_x"}, 32'(xpos_flat), 32'({10'd621, 10'd462, 10'd303}));
    check_val({tag, "_y"}, 32'(ypos_flat), 32'({10'd275, 10'd275, 10'd275}));
    check_val({tag, "_sel"}, 32'(sel_idx), 32'd0);
    check_val({tag, "_pulse"}, 32'(step_pulse), 32'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1);
  end

  initial begin
    int p;
    model_reset();
    run(1'b0, B_NONE, 1'b1);
    run(1'b0, B_NONE, 1'b1);
    check_reset_state("reset");
    run(1'b0, B_NONE, 1'b0);

    // Auto-repeat: steps on ticks 1, 5, 7, 9.
    p = n_pulse;
    frames(10, B_RIGHT);
    frames(1, B_NONE);
    check_val("repeat_x0", 32'(xpos_flat[9:0]), 32'd311);
    check_val("repeat_x12", 32'(xpos_flat[29:10]), 32'({10'd621, 10'd462}));
    check_val("repeat_pulses", 32'(n_pulse - p), 32'd4);

    // Horizontal and vertical wrap.
    for (int i = 0; i < 83; i++) tap(B_LEFT);
    check_val("wrap_x145", 32'(xpos_flat[9:0]), 32'd145);
    tap(B_LEFT);
    check_val("wrap_left", 32'(xpos_flat[9:0]), 32'd783);
    tap(B_RIGHT);
    check_val("wrap_right", 32'(xpos_flat[9:0]), 32'd144);
    for (int i = 0; i < 120; i++) tap(B_UP);
    check_val("wrap_y35", 32'(ypos_flat[9:0]), 32'd35);
    tap(B_UP);
    check_val("wrap_up", 32'(ypos_flat[9:0]), 32'd515);

    // Selection cycling, rejection while a direction is held, edge on frame_tick.
    for (int i = 0; i < 3; i++) begin
      run(1'b0, B_SEL, 1'b0);
      run(1'b0, B_NONE, 1'b0);
      check_val("sel_cycle", 32'(sel_idx), 32'((i + 1) % 3));
    end
    run(1'b0, B_DOWN, 1'b0);
    run(1'b0, B_DOWN | B_SEL, 1'b0);
    run(1'b0, B_DOWN, 1'b0);
    run(1'b0, B_NONE, 1'b0);
    check_val("sel_blocked", 32'(sel_idx), 32'd0);
    p = n_pulse;
    run(1'b1, B_SEL, 1'b0);
    run(1'b0, B_NONE, 1'b0);
    check_val("sel_on_tick", 32'(sel_idx), 32'd1);
    check_val("sel_no_step", 32'(n_pulse - p), 32'd0);
    tap(B_DOWN);
    check_val("sel_down_y", 32'(ypos_flat), 32'({10'd275, 10'd277, 10'd515}));

    // Direction change and release.
    p = n_pulse;
    frames(3, B_RIGHT);
    frames(1, B_UP);
    check_val("chg_pulses", 32'(n_pulse - p), 32'd2);
    check_val("chg_y1", 32'(ypos_flat[19:10]), 32'd275);
    check_val("chg_x1", 32'(xpos_flat[19:10]), 32'd464);
    frames(1, B_NONE);
    check_val("release_nostep", 32'(n_pulse - p), 32'd2);
    frames(1, B_UP);
    check_val("idle_restep", 32'(n_pulse - p), 32'd3);
    frames(1, B_NONE);

    // Reset while in REPEAT.
    frames(6, B_RIGHT);
    check_val("pre_reset_x1", 32'(xpos_flat[19:10]), 32'd468);
    run(1'b1, B_RIGHT, 1'b1);
    check_reset_state("mid_reset");
    run(1'b0, B_NONE, 1'b0);

    // Simultaneous right+up.
    p = n_pulse;
    frames(1, B_RIGHT | B_UP);
    check_val("diag_x0", 32'(xpos_flat[9:0]), 32'd305);
`ifdef DIAG_MOVE_EN
    check_val("diag_y0", 32'(ypos_flat[9:0]), 32'd273);
`else
    check_val("diag_y0", 32'(ypos_flat[9:0]), 32'd275);
`endif
    check_val("diag_pulses", 32'(n_pulse - p), 32'd1);
    frames(1, B_NONE);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
